// File: rtl/decoder_pkg.sv
// Shared constants and types for the MIPS-32 instruction field decoder.
package decoder_pkg;

  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned SHAMT_MSB  = 10;
  localparam int unsigned SHAMT_LSB  = 6;
  localparam int unsigned FUNCT_MSB  = 5;
  localparam int unsigned FUNCT_LSB  = 0;
  localparam int unsigned ADDR_MSB   = 25;
  localparam int unsigned ADDR_LSB   = 0;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  typedef enum logic [1:0] {
    CLASS_R = 2'd0,
    CLASS_I = 2'd1,
    CLASS_J = 2'd2
  } instr_class_t;

endpackage

// File: rtl/decoder_fields.sv
// Combinational field slicing and format classification of one instruction word.
// Optional build macro DECODER_FIELD_MASK_EN zeroes fields not meaningful for the format.
module decoder_fields
  import decoder_pkg::*;
(
  input  logic [31:0]  memory,
  output logic [5:0]   opcode,
  output logic [5:0]   funct,
  output logic [4:0]   rs,
  output logic [4:0]   rt,
  output logic [4:0]   rd,
  output logic [4:0]   shamt,
  output logic [25:0]  addr,
  output logic [15:0]  imm,
  output instr_class_t instr_class
);

  always_comb begin
    opcode = memory[OPCODE_MSB:OPCODE_LSB];
    rs     = memory[RS_MSB:RS_LSB];
    rt     = memory[RT_MSB:RT_LSB];
    rd     = memory[RD_MSB:RD_LSB];
    shamt  = memory[SHAMT_MSB:SHAMT_LSB];
    funct  = memory[FUNCT_MSB:FUNCT_LSB];
    addr   = memory[ADDR_MSB:ADDR_LSB];
    imm    = memory[IMM_MSB:IMM_LSB];

    // An X/Z opcode matches no item and therefore lands in I.
    case (opcode)
      OP_RTYPE:     instr_class = CLASS_R;
      OP_J, OP_JAL: instr_class = CLASS_J;
      default:      instr_class = CLASS_I;
    endcase

`ifdef DECODER_FIELD_MASK_EN
    case (instr_class)
      CLASS_R: begin
        addr = '0;
        imm  = '0;
      end
      CLASS_J: begin
        rs    = '0;
        rt    = '0;
        rd    = '0;
        shamt = '0;
        funct = '0;
        imm   = '0;
      end
      default: begin
        rd    = '0;
        shamt = '0;
        funct = '0;
        addr  = '0;
      end
    endcase
`endif
  end

endmodule

// File: rtl/decoder.sv
// Registered MIPS-32 instruction decoder: all fields appear one clock after capture.
// Honours DECODER_FIELD_MASK_EN through decoder_fields.
module decoder
  import decoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] memory,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [25:0] addr,
  output logic [15:0] imm,
  output logic [1:0]  instr_class
);

  logic [5:0]   opcode_c;
  logic [5:0]   funct_c;
  logic [4:0]   rs_c;
  logic [4:0]   rt_c;
  logic [4:0]   rd_c;
  logic [4:0]   shamt_c;
  logic [25:0]  addr_c;
  logic [15:0]  imm_c;
  instr_class_t class_c;

  decoder_fields u_fields (
    .memory      (memory),
    .opcode      (opcode_c),
    .funct       (funct_c),
    .rs          (rs_c),
    .rt          (rt_c),
    .rd          (rd_c),
    .shamt       (shamt_c),
    .addr        (addr_c),
    .imm         (imm_c),
    .instr_class (class_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode      <= '0;
      funct       <= '0;
      rs          <= '0;
      rt          <= '0;
      rd          <= '0;
      shamt       <= '0;
      addr        <= '0;
      imm         <= '0;
      instr_class <= CLASS_R;
    end else begin
      opcode      <= opcode_c;
      funct       <= funct_c;
      rs          <= rs_c;
      rt          <= rt_c;
      rd          <= rd_c;
      shamt       <= shamt_c;
      addr        <= addr_c;
      imm         <= imm_c;
      instr_class <= class_c;
    end
  end

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for decoder: stimulus pushes model results, a monitor pops and compares.
module tb_decoder;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [25:0] addr;
    logic [15:0] imm;
    logic [1:0]  cls;
  } fields_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] memory = '0;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [25:0] addr;
  logic [15:0] imm;
  logic [1:0]  instr_class;

  int unsigned checks = 0;
  int unsigned errors = 0;
  fields_t     expq[$];
  fields_t     last_exp = '0;

  decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .memory      (memory),
    .opcode      (opcode),
    .funct       (funct),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .addr        (addr),
    .imm         (imm),
    .instr_class (instr_class)
  );

  always #5 clk = ~clk;

  function automatic fields_t actual();
    fields_t a;
    a.opcode = opcode; a.funct = funct; a.rs = rs; a.rt = rt; a.rd = rd;
    a.shamt = shamt; a.addr = addr; a.imm = imm; a.cls = instr_class;
    return a;
  endfunction

  // Reference: fields by division/modulo, format from the opcode value.
  function automatic fields_t model(input logic [31:0] w);
    fields_t e;
    int unsigned v;
    int unsigned op;
    v = w;
    op = v / (1 << 26);
    e.opcode = 6'(op);
    e.rs     = 5'((v / (1 << 21)) % 32);
    e.rt     = 5'((v / (1 << 16)) % 32);
    e.rd     = 5'((v / (1 << 11)) % 32);
    e.shamt  = 5'((v / 64) % 32);
    e.funct  = 6'(v % 64);
    e.addr   = 26'(v % (1 << 26));
    e.imm    = 16'(v % 65536);
    if (op == 0)               e.cls = 2'd0;
    else if (op == 2 || op == 3) e.cls = 2'd2;
    else                       e.cls = 2'd1;
`ifdef DECODER_FIELD_MASK_EN
    if (e.cls == 2'd0) begin
      e.addr = '0; e.imm = '0;
    end else if (e.cls == 2'd2) begin
      e.rs = '0; e.rt = '0; e.rd = '0; e.shamt = '0; e.funct = '0; e.imm = '0;
    end else begin
      e.rd = '0; e.shamt = '0; e.funct = '0; e.addr = '0;
    end
`endif
    return e;
  endfunction

  task automatic compare(input string name, input fields_t act, input fields_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got op=%h fn=%h rs=%h rt=%h rd=%h sh=%h addr=%h imm=%h cls=%0d, expected op=%h fn=%h rs=%h rt=%h rd=%h sh=%h addr=%h imm=%h cls=%0d",
               name, act.opcode, act.funct, act.rs, act.rt, act.rd, act.shamt, act.addr, act.imm, act.cls,
               exp.opcode, exp.funct, exp.rs, exp.rt, exp.rd, exp.shamt, exp.addr, exp.imm, exp.cls);
    end
  endtask

  // Monitor: every capturing edge presents one result.
  always begin
    @(posedge clk);
    #1;
    if (rst_n && expq.size() > 0) begin
      last_exp = expq.pop_front();
      compare("capture", actual(), last_exp);
    end
  end

  task automatic apply(input logic [31:0] w);
    @(posedge clk);
    #2;
    memory = w;
    expq.push_back(model(w));
    #1;
    compare("hold_before_edge", actual(), last_exp);
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    compare("async_reset", actual(), '0);
    expq.delete();
    last_exp = '0;
    memory = $urandom;
    @(negedge clk);
    compare("reset_hold", actual(), '0);
    memory = $urandom;
    rst_n = 1'b1;
    expq.push_back(model(memory));
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0: w[31:26] = 6'h00;
      1: w[31:26] = 6'h02;
      2: w[31:26] = 6'h03;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    logic [31:0] directed [5];
    directed[0] = 32'h00000003;
    directed[1] = 32'h0C000003;
    directed[2] = 32'hC0000003;
    directed[3] = 32'h80000003;
    directed[4] = 32'h03C00003;

    memory = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    compare("reset_state", actual(), '0);
    rst_n = 1'b1;
    expq.push_back(model(memory));

    foreach (directed[i]) apply(directed[i]);
    for (int i = 0; i < 60; i++) apply(rand_word());
    mid_reset();
    for (int i = 0; i < 60; i++) apply(rand_word());
    mid_reset();
    for (int i = 0; i < 20; i++) apply(rand_word());

    repeat (3) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d results pending, expected 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
